// File: rtl/aes256_cbc_framer_if.sv
// AXI-Stream bundle shared by the framer's payload input and framed output.
interface axis_if #(
    parameter int W = 8
);
    logic [W-1:0]   tdata;
    logic           tvalid;
    logic           tready;
    logic [W/8-1:0] tkeep;
    logic           tlast;
    logic           tuser;

    modport master (output tdata, tvalid, tkeep, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/aes256_cbc_framer.sv
// Framer for the AES-256 CBC core: emits key words, IV words, then the payload
// passed straight through, with direction on tuser and a generated tlast.
module aes256_cbc_framer #(
    parameter int M_AXIS_WIDTH = 8
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Cmd_valid,
    output logic         Cmd_ready,
    input  logic [255:0] Cmd_key,
    input  logic [127:0] Cmd_iv,
    input  logic         Cmd_encrypt,
    input  logic [15:0]  Cmd_blocks,
    axis_if.slave        S_axis,
    axis_if.master       M_axis,
    output logic         Frame_error
);
    localparam int W  = M_AXIS_WIDTH;
    localparam int KW = 256 / W;
    localparam int BW = 128 / W;
    localparam int CW = $clog2(KW);
    localparam int KB = W / 8;
    localparam logic [CW-1:0] KW_LAST = CW'(KW - 1);
    localparam logic [CW-1:0] BW_LAST = CW'(BW - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_KEY  = 4'b0010,
        ST_IV   = 4'b0100,
        ST_DATA = 4'b1000
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_word_cnt;
    logic [15:0]    r_block_cnt;
    logic [255:0]   r_key;
    logic [127:0]   r_iv;
    logic           r_encrypt;
    logic [15:0]    r_blocks;
    logic           r_zero_err;

    state_t         w_state_next;
    logic [CW-1:0]  w_word_cnt_next;
    logic [15:0]    w_block_cnt_next;
    logic           w_m_tvalid;
    logic [W-1:0]   w_m_tdata;
    logic           w_s_tready;
    logic           w_m_tlast;
    logic           w_cmd_hs;
    logic           w_s_hs;
    logic           w_last_word;
    logic           w_last_block;
    logic [W-1:0]   w_key_words [KW];
    logic [W-1:0]   w_iv_words  [KW];

    // IV table is padded to the key depth so both share the word counter as index.
    for (genvar gi = 0; gi < KW; gi++) begin : g_words
        assign w_key_words[gi] = r_key[gi*W +: W];
        if (gi < BW) begin : g_iv
            assign w_iv_words[gi] = r_iv[gi*W +: W];
        end else begin : g_pad
            assign w_iv_words[gi] = '0;
        end
    end

    assign w_cmd_hs     = Cmd_valid && (r_state == ST_IDLE);
    assign w_s_hs       = (r_state == ST_DATA) && S_axis.tvalid && M_axis.tready;
    assign w_last_word  = (r_word_cnt == BW_LAST);
    assign w_last_block = (r_block_cnt == (r_blocks - 16'd1));
    assign w_m_tlast    = (r_state == ST_DATA) && w_last_word && w_last_block;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state     <= ST_IDLE;
            r_word_cnt  <= '0;
            r_block_cnt <= '0;
            r_key       <= '0;
            r_iv        <= '0;
            r_encrypt   <= 1'b0;
            r_blocks    <= '0;
            r_zero_err  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_word_cnt  <= w_word_cnt_next;
            r_block_cnt <= w_block_cnt_next;
            r_zero_err  <= w_cmd_hs && (Cmd_blocks == 16'd0);
            if (w_cmd_hs) begin
                r_key     <= Cmd_key;
                r_iv      <= Cmd_iv;
                r_encrypt <= Cmd_encrypt;
                r_blocks  <= Cmd_blocks;
            end
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_word_cnt_next  = r_word_cnt;
        w_block_cnt_next = r_block_cnt;
        w_m_tvalid       = 1'b0;
        w_m_tdata        = '0;
        w_s_tready       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Cmd_valid) begin
                    w_word_cnt_next  = '0;
                    w_block_cnt_next = '0;
                    // A zero-block command is rejected without leaving idle.
                    if (Cmd_blocks != 16'd0) begin
                        w_state_next = ST_KEY;
                    end
                end
            end
            ST_KEY: begin
                w_m_tvalid = 1'b1;
                w_m_tdata  = w_key_words[r_word_cnt];
                if (M_axis.tready) begin
                    if (r_word_cnt == KW_LAST) begin
                        w_word_cnt_next = '0;
                        w_state_next    = ST_IV;
                    end else begin
                        w_word_cnt_next = r_word_cnt + CNT_ONE;
                    end
                end
            end
            ST_IV: begin
                w_m_tvalid = 1'b1;
                w_m_tdata  = w_iv_words[r_word_cnt];
                if (M_axis.tready) begin
                    if (r_word_cnt == BW_LAST) begin
                        w_word_cnt_next = '0;
                        w_state_next    = ST_DATA;
                    end else begin
                        w_word_cnt_next = r_word_cnt + CNT_ONE;
                    end
                end
            end
            ST_DATA: begin
                w_m_tvalid = S_axis.tvalid;
                w_s_tready = M_axis.tready;
                w_m_tdata  = S_axis.tdata;
                if (w_s_hs) begin
                    if (w_last_word) begin
                        w_word_cnt_next  = '0;
                        w_block_cnt_next = r_block_cnt + 16'd1;
                        if (w_last_block) begin
                            w_state_next = ST_IDLE;
                        end
                    end else begin
                        w_word_cnt_next = r_word_cnt + CNT_ONE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign Cmd_ready     = (r_state == ST_IDLE);
    assign M_axis.tvalid = w_m_tvalid;
    assign M_axis.tdata  = w_m_tdata;
    assign M_axis.tlast  = w_m_tlast;
    assign M_axis.tkeep  = {KB{w_m_tvalid}};
    assign M_axis.tuser  = (r_state != ST_IDLE) && r_encrypt;
    assign S_axis.tready = w_s_tready;
    // Payload tlast disagreement is flagged in the handshake cycle itself.
    assign Frame_error   = r_zero_err || (w_s_hs && (S_axis.tlast != w_m_tlast));
endmodule

// File: tb/tb_aes256_cbc_framer.sv
// Directed bench for aes256_cbc_framer: frame vector table on a W=8 instance,
// plus zero-block, mid-frame reset and a W=32 multi-block sequence.
module tb_aes256_cbc_framer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         cmd_valid8, cmd_valid32, cmd_ready8, cmd_ready32, fe8, fe32;
    logic [255:0] cmd_key;
    logic [127:0] cmd_iv;
    logic         cmd_encrypt;
    logic [15:0]  cmd_blocks;

    axis_if #(.W(8))  s8 ();
    axis_if #(.W(8))  m8 ();
    axis_if #(.W(32)) s32 ();
    axis_if #(.W(32)) m32 ();
    assign s8.tkeep  = '1;
    assign s8.tuser  = 1'b0;
    assign s32.tkeep = '1;
    assign s32.tuser = 1'b0;

    aes256_cbc_framer #(.M_AXIS_WIDTH(8)) u_dut8 (
        .Clk(clk), .Rst(rst), .Cmd_valid(cmd_valid8), .Cmd_ready(cmd_ready8),
        .Cmd_key(cmd_key), .Cmd_iv(cmd_iv), .Cmd_encrypt(cmd_encrypt), .Cmd_blocks(cmd_blocks),
        .S_axis(s8), .M_axis(m8), .Frame_error(fe8)
    );

    aes256_cbc_framer #(.M_AXIS_WIDTH(32)) u_dut32 (
        .Clk(clk), .Rst(rst), .Cmd_valid(cmd_valid32), .Cmd_ready(cmd_ready32),
        .Cmd_key(cmd_key), .Cmd_iv(cmd_iv), .Cmd_encrypt(cmd_encrypt), .Cmd_blocks(cmd_blocks),
        .S_axis(s32), .M_axis(m32), .Frame_error(fe32)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int   id;
        int   blocks;
        logic enc;
        logic fixed;      // 1: FIPS-197 style key/IV/payload pattern
        int   rdy_mode;   // 0: tready held 1, 1: tready 1,0,0,1
        logic vld_rand;
        int   err_word;   // payload index carrying a stray tlast, -1 for none
        int   exp_beats;
        int   exp_errs;
    } vec_t;

    vec_t       vecs[4];
    logic [7:0] pay8[64];
    logic [7:0] exp8[$];
    logic [31:0] pay32[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_frame8(input vec_t v);
        int   npay, nb, pidx, cyc, errs, err_at;
        logic hold_v, stalled_prev;
        logic [7:0] prev_data;
        npay = v.blocks * 16;
        for (int i = 0; i < 32; i++) cmd_key[i*8 +: 8] = v.fixed ? 8'(i) : 8'($urandom);
        for (int i = 0; i < 16; i++) cmd_iv[i*8 +: 8] = v.fixed ? 8'h00 : 8'($urandom);
        for (int i = 0; i < npay; i++) pay8[i] = v.fixed ? 8'(i * 17) : 8'($urandom);
        exp8.delete();
        for (int i = 0; i < 32; i++) exp8.push_back(cmd_key[i*8 +: 8]);
        for (int i = 0; i < 16; i++) exp8.push_back(cmd_iv[i*8 +: 8]);
        for (int i = 0; i < npay; i++) exp8.push_back(pay8[i]);
        cmd_encrypt = v.enc;
        cmd_blocks  = 16'(v.blocks);

        @(posedge clk); #1;
        cmd_valid8 = 1'b1;
        @(negedge clk);
        chk("cmd_ready_idle", 64'(cmd_ready8), 64'd1);

        nb = 0; pidx = 0; cyc = 0; errs = 0; err_at = -1;
        hold_v = 1'b0; stalled_prev = 1'b0; prev_data = '0;
        while (nb < v.exp_beats && cyc < 4000) begin
            @(posedge clk); #1;
            cmd_valid8 = 1'b0;
            m8.tready  = (v.rdy_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (!hold_v) s8.tvalid = (pidx < npay) && (v.vld_rand ? 1'($urandom_range(0, 1)) : 1'b1);
            s8.tdata = pay8[pidx];
            s8.tlast = (pidx == npay - 1) || (pidx == v.err_word);
            @(negedge clk);
            if (cyc == 0) chk("first_key_beat_valid", 64'(m8.tvalid), 64'd1);
            if (stalled_prev) begin
                chk("stall_hold_valid", 64'(m8.tvalid), 64'd1);
                chk("stall_hold_data", 64'(m8.tdata), 64'(prev_data));
            end
            if (m8.tvalid && m8.tready) begin
                chk("beat_data", 64'(m8.tdata), 64'(exp8[nb]));
                chk("beat_tlast", 64'(m8.tlast), 64'(nb == v.exp_beats - 1));
                chk("beat_tuser", 64'(m8.tuser), 64'(v.enc));
                chk("beat_tkeep", 64'(m8.tkeep), 64'd1);
                nb++;
            end
            stalled_prev = m8.tvalid && !m8.tready;
            prev_data    = m8.tdata;
            hold_v       = s8.tvalid && !s8.tready;
            if (fe8) begin
                errs++;
                err_at = pidx;
            end
            if (s8.tvalid && s8.tready) pidx++;
            cyc++;
        end
        chk("beat_count", 64'(nb), 64'(v.exp_beats));
        chk("payload_consumed", 64'(pidx), 64'(npay));
        chk("frame_error_count", 64'(errs), 64'(v.exp_errs));
        if (v.exp_errs > 0) chk("frame_error_word", 64'(err_at), 64'(v.err_word));

        @(posedge clk); #1;
        m8.tready = 1'b1;
        s8.tvalid = 1'b0;
        s8.tlast  = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after", 64'(cmd_ready8), 64'd1);
        chk("tvalid_after", 64'(m8.tvalid), 64'd0);
        $display("[TB] frame %0d: blocks=%0d beats=%0d cycles=%0d frame_errors=%0d",
                 v.id, v.blocks, nb, cyc, errs);
    endtask

    initial begin
        int nb, pidx, errs;
        logic [31:0] exp_w;

        vecs[0] = '{id: 0, blocks: 1, enc: 1'b1, fixed: 1'b1, rdy_mode: 0, vld_rand: 1'b0,
                    err_word: -1, exp_beats: 64, exp_errs: 0};
        vecs[1] = '{id: 1, blocks: 1, enc: 1'b1, fixed: 1'b1, rdy_mode: 1, vld_rand: 1'b1,
                    err_word: -1, exp_beats: 64, exp_errs: 0};
        vecs[2] = '{id: 2, blocks: 2, enc: 1'b1, fixed: 1'b0, rdy_mode: 0, vld_rand: 1'b0,
                    err_word: 5, exp_beats: 80, exp_errs: 1};
        vecs[3] = '{id: 3, blocks: 3, enc: 1'b0, fixed: 1'b0, rdy_mode: 1, vld_rand: 1'b1,
                    err_word: -1, exp_beats: 96, exp_errs: 0};

        rst = 1'b1;
        cmd_valid8 = 1'b0; cmd_valid32 = 1'b0;
        cmd_key = '0; cmd_iv = '0; cmd_encrypt = 1'b0; cmd_blocks = '0;
        m8.tready = 1'b1; s8.tvalid = 1'b0; s8.tdata = '0; s8.tlast = 1'b0;
        m32.tready = 1'b1; s32.tvalid = 1'b0; s32.tdata = '0; s32.tlast = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready8), 64'd1);
        chk("rst_m_tvalid", 64'(m8.tvalid), 64'd0);
        chk("rst_m_tdata", 64'(m8.tdata), 64'd0);
        chk("rst_m_tlast", 64'(m8.tlast), 64'd0);
        chk("rst_m_tuser", 64'(m8.tuser), 64'd0);
        chk("rst_m_tkeep", 64'(m8.tkeep), 64'd0);
        chk("rst_s_tready", 64'(s8.tready), 64'd0);
        chk("rst_frame_error", 64'(fe8), 64'd0);
        chk("rst_cmd_ready32", 64'(cmd_ready32), 64'd1);

        for (int k = 0; k < 4; k++) run_frame8(vecs[k]);

        // Zero-block command: error pulse one cycle after acceptance, nothing emitted.
        cmd_blocks = 16'd0;
        @(posedge clk); #1 cmd_valid8 = 1'b1;
        @(posedge clk); #1 cmd_valid8 = 1'b0;
        @(negedge clk);
        chk("zero_blk_frame_error", 64'(fe8), 64'd1);
        chk("zero_blk_cmd_ready", 64'(cmd_ready8), 64'd1);
        chk("zero_blk_tvalid", 64'(m8.tvalid), 64'd0);
        errs = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (fe8 || m8.tvalid) errs++;
        end
        chk("zero_blk_quiet", 64'(errs), 64'd0);
        $display("[TB] zero-block command done");

        // Reset during IV beat 3.
        for (int i = 0; i < 8; i++) cmd_key[i*32 +: 32] = $urandom;
        for (int i = 0; i < 4; i++) cmd_iv[i*32 +: 32] = $urandom;
        cmd_blocks = 16'd1; cmd_encrypt = 1'b1;
        m8.tready = 1'b1; s8.tvalid = 1'b0;
        @(posedge clk); #1 cmd_valid8 = 1'b1;
        @(posedge clk); #1 cmd_valid8 = 1'b0;
        repeat (35) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_iv_beat3", 64'(m8.tdata), 64'(cmd_iv[31:24]));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_tvalid", 64'(m8.tvalid), 64'd0);
        chk("rst_mid_cmd_ready", 64'(cmd_ready8), 64'd1);
        $display("[TB] reset mid-frame done");
        run_frame8(vecs[0]);

        // W=32, three blocks, decrypt.
        for (int i = 0; i < 8; i++) cmd_key[i*32 +: 32] = $urandom;
        for (int i = 0; i < 4; i++) cmd_iv[i*32 +: 32] = $urandom;
        for (int i = 0; i < 12; i++) pay32[i] = $urandom;
        cmd_blocks = 16'd3; cmd_encrypt = 1'b0;
        @(posedge clk); #1 cmd_valid32 = 1'b1;
        nb = 0; pidx = 0; errs = 0;
        for (int cyc = 0; cyc < 200 && nb < 24; cyc++) begin
            @(posedge clk); #1;
            cmd_valid32 = 1'b0;
            s32.tvalid  = (pidx < 12);
            s32.tdata   = pay32[pidx % 12];
            s32.tlast   = (pidx == 11);
            @(negedge clk);
            if (m32.tvalid && m32.tready) begin
                exp_w = (nb < 8) ? cmd_key[nb*32 +: 32] :
                        (nb < 12) ? cmd_iv[(nb-8)*32 +: 32] : pay32[nb-12];
                if (nb == 0) chk("w32_key_word0", 64'(m32.tdata), 64'(cmd_key[31:0]));
                chk("w32_beat_data", 64'(m32.tdata), 64'(exp_w));
                chk("w32_beat_tuser", 64'(m32.tuser), 64'd0);
                chk("w32_beat_tlast", 64'(m32.tlast), 64'(nb == 23));
                chk("w32_beat_tkeep", 64'(m32.tkeep), 64'hF);
                nb++;
            end
            if (fe32) errs++;
            if (s32.tvalid && s32.tready) pidx++;
        end
        chk("w32_beat_count", 64'(nb), 64'd24);
        chk("w32_frame_errors", 64'(errs), 64'd0);
        @(posedge clk); #1 s32.tvalid = 1'b0;
        @(negedge clk);
        chk("w32_cmd_ready_after", 64'(cmd_ready32), 64'd1);
        $display("[TB] frame w32: blocks=3 beats=%0d frame_errors=%0d", nb, errs);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/aes256_cbc_framer.md
# aes256_cbc_framer

Transmit-side framer for the AES-256 CBC core. It takes a parallel command (key, IV, direction, block count) and a raw payload AXI-Stream, and emits the framed stream the core consumes: key words, then IV words, then payload blocks. `tuser` carries the direction on every beat, and `tlast` is set only on the final word of the final block. It sits directly upstream of the core's slave port and is the only producer on that port.

## Interface
- `M_AXIS_WIDTH`, default 8: data width of both stream ports in bits. Legal values are 8, 16, 32, 64, 128.
- `Clk` input, 1 bit: single clock for all logic.
- `Rst` input, 1 bit: reset, synchronous and active-high.
- `Cmd_valid` input, 1 bit: command present.
- `Cmd_ready` output, 1 bit: framer can accept a command. High only in ST_IDLE.
- `Cmd_key` input, 256 bits: AES-256 key. Bits [W-1:0] are sent first.
- `Cmd_iv` input, 128 bits: CBC IV. Bits [W-1:0] are sent first.
- `Cmd_encrypt` input, 1 bit: 1 = encrypt, 0 = decrypt.
- `Cmd_blocks` input, 16 bits: number of 128-bit payload blocks.
- `S_axis` (axis_if.slave), M_AXIS_WIDTH bits: raw payload input. `tdata`, `tvalid`, `tready`, `tlast`.
- `M_axis` (axis_if.master), M_AXIS_WIDTH bits: framed output. `tdata`, `tvalid`, `tready`, `tkeep`, `tlast`, `tuser`.
- `Frame_error` output, 1 bit: one-cycle pulse on a payload `tlast` mismatch or a zero-block command.

## Operation
- Constants:
  - W = M_AXIS_WIDTH
  - KW = 256/W (key words)
  - BW = 128/W (words per block)
- Counters:
  - `word_cnt` has width $clog2(KW).
  - `block_cnt` is 16 bits.
- State machine, one-hot, with states ST_IDLE, ST_KEY, ST_IV, ST_DATA.
- ST_IDLE:
  - `Cmd_ready` = 1.
  - When `Cmd_valid` & `Cmd_ready`, latch key, IV, encrypt and blocks, clear both counters, and go to ST_KEY.
  - If the latched `Cmd_blocks` is 0, pulse `Frame_error`, stay in ST_IDLE and emit nothing.
- ST_KEY:
  - `M_axis.tvalid` = 1.
  - `tdata` = key[word_cnt*W +: W].
  - On an M handshake, `word_cnt`++. On the handshake with word_cnt == KW-1, set word_cnt = 0 and go to ST_IV.
- ST_IV:
  - Same as ST_KEY, using iv[word_cnt*W +: W].
  - On the handshake with word_cnt == BW-1, go to ST_DATA.
- ST_DATA is a combinational pass-through:
  - `M_axis.tvalid` = `S_axis.tvalid`
  - `S_axis.tready` = `M_axis.tready`
  - `M_axis.tdata` = `S_axis.tdata`
- ST_DATA counting:
  - On each handshake, `word_cnt`++.
  - When word_cnt == BW-1, set word_cnt = 0 and increment `block_cnt`.
  - On the handshake of the last word of block blocks-1, return to ST_IDLE.
- `M_axis.tlast` is generated internally and is 1 only in ST_DATA when word_cnt == BW-1 and block_cnt == blocks-1. The input `tlast` is never forwarded.
- `M_axis.tuser` = latched encrypt on every beat in every non-idle state, including key and IV beats.
- `M_axis.tkeep` = all ones whenever `tvalid` = 1, and 0 otherwise.
- `S_axis.tready` = 0 in all states except ST_DATA.
- `Frame_error` is pulsed for one cycle on a payload handshake when `S_axis.tlast` ≠ the generated `tlast`. The data is still forwarded and the framing is unaffected.
- Block count arithmetic is unsigned 16-bit. A count of 65535 is legal.

## Timing
- Reset values:
  - state = ST_IDLE
  - `Cmd_ready` = 1
  - `M_axis.tvalid` / `tlast` / `tuser` / `tkeep` / `tdata` = 0
  - `S_axis.tready` = 0
  - `Frame_error` = 0
  - all counters = 0
- Reset asserted mid-frame aborts the frame. The next cycle after `Rst` drops is ST_IDLE, and partial output is not completed.
- If a command is accepted at edge N, the first key beat is valid in cycle N+1.
- Total output beats per frame = KW + BW + blocks*BW.
- Key and IV beats proceed at one per cycle while `M_axis.tready` = 1. A key or IV beat stays stable while `tready` = 0.
- Payload path adds zero latency and holds no storage.
- After the final beat, the framer is in ST_IDLE on the next cycle. The minimum gap between frames is 1 cycle: the command handshake cycle.
- A `Cmd_valid` arriving while busy is held off with `Cmd_ready` = 0. Command inputs are sampled only at the handshake.

## Test plan
- **Single FIPS-197 block, W=8.**
  - Stimulus: key 00 01 .. 1f, IV all 0, encrypt=1, blocks=1, payload 00 11 22 .. ff, `tready` held 1.
  - Required: 64 beats.
    - Beats 0-31 are 00..1f.
    - Beats 32-47 are 00.
    - Beats 48-63 are 00..ff.
    - `tuser` = 1 on all beats; `tlast` only on beat 63; `Cmd_ready` = 1 the cycle after.
- **Multi-block, W=32.**
  - Stimulus: blocks=3, decrypt.
  - Required: 24 beats, `tuser` = 0, `tlast` only on beat 23. Key word 0 = key[31:0].
- **Backpressure, W=8.**
  - Stimulus: `M_axis.tready` toggling 1,0,0,1 with random payload `tvalid`.
  - Required: beats stable while stalled; no drops or duplicates; beat stream identical to the no-stall run.
- **Payload tlast mismatch.**
  - Stimulus: payload `tlast` asserted on word 5 of block 0 with blocks=2, W=8.
  - Required: `Frame_error` pulses exactly once at that handshake. The output has `tlast` only on the final beat (word 15 of block 1).
- **Zero-block command.**
  - Stimulus: blocks=0.
  - Required: `Frame_error` pulse one cycle after acceptance, no `M_axis.tvalid`, `Cmd_ready` still 1.
- **Reset mid-frame.**
  - Stimulus: `Rst` asserted during ST_IV beat 3.
  - Required: next cycle `M_axis.tvalid` = 0 and `Cmd_ready` = 1. A new command then produces a complete, correct frame.
